swap_ctrl: RTL
==============

SWAP_CTRL -- requirements
Module: swap_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning register-file address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_f, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, swap request, sampled only in IDLE.
REQ-006 The block SHALL have ports rs_addr and rt_addr, input, ADDR_W, the register pair to swap.
REQ-007 The block SHALL have ports rs_data and rt_data, input, DATA_W, combinational register-file read data.
REQ-008 The block SHALL have ports rs_raddr and rt_raddr, output, ADDR_W, the latched read addresses.
REQ-009 The block SHALL have ports swap_a and swap_b, output, DATA_W, the held swap operands for the swap-data mux.
REQ-010 The block SHALL have port out_sel, output, 1, the mux select: 0 -> swap_a, 1 -> swap_b.
REQ-011 The block SHALL have port wb_addr, output, ADDR_W, the register-file write address.
REQ-012 The block SHALL have port rf_we, output, 1, the register-file write enable.
REQ-013 The block SHALL have ports busy and done, output, 1: busy is high in any non-IDLE state; done is a one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, READ, WR_RS, WR_RT, DONE; encoding is free.
REQ-015 In IDLE with start=1, the FSM SHALL latch rs_addr/rt_addr into internal regs and go to READ; with start=0 it SHALL stay in IDLE.
REQ-016 rs_raddr/rt_raddr SHALL always equal the latched addresses.
REQ-017 On the edge leaving READ, the FSM SHALL capture swap_a<=rs_data and swap_b<=rt_data; swap_a/swap_b SHALL hold in all other states.
REQ-018 From READ, the FSM SHALL go to DONE if latched rs==rt (no write cycles), else to WR_RS.
REQ-019 In WR_RS: rf_we=1, wb_addr=latched rs, out_sel=1 (old rt value); next state WR_RT.
REQ-020 In WR_RT: rf_we=1, wb_addr=latched rt, out_sel=0 (old rs value); next state DONE.
REQ-021 In DONE: done=1 for exactly one cycle, rf_we=0; next state IDLE.
REQ-022 In IDLE, READ and DONE: rf_we=0, out_sel=0, wb_addr=0.
REQ-023 start SHALL be ignored while busy=1, with no queuing.
REQ-024 Latency: start sampled at edge k SHALL give done high in the cycle after edge k+3 (k+1 for rs==rt); back-to-back swaps SHALL be possible with start held, re-sampled in IDLE.
REQ-025 Operand capture in READ SHALL make the writes in WR_RS/WR_RT use pre-swap values even though WR_RS modifies rs before WR_RT.

Reset
REQ-026 While rst_f=0, the block SHALL force the state to IDLE and drive all outputs and latched regs to 0 (busy=0, done=0, rf_we=0, out_sel=0), independent of clk.
REQ-027 Reset asserted mid-operation SHALL abort immediately with no further writes; a partially completed swap SHALL NOT be resumed.
REQ-028 After rst_f deasserts, the first start SHALL be honoured on the first rising edge at which it is sampled.

Verification
REQ-029 The bench SHALL check: rs=2 (0xAAAA0000), rt=5 (0x0000BBBB), start pulse -> WR_RS writes 0x0000BBBB to addr 2, then WR_RT writes 0xAAAA0000 to addr 5, and done pulses once, 4 cycles after start.
REQ-030 The bench SHALL check: rs=rt=7, start -> rf_we stays 0 throughout and done pulses 2 cycles after start.
REQ-031 The bench SHALL check: second start asserted during WR_RS -> ignored; exactly two writes; busy stays high until DONE completes.
REQ-032 The bench SHALL check: start held high for 10 cycles with rs=1, rt=3 -> two complete swaps, each done separated by 5 cycles, registers end at their original values.
REQ-033 The bench SHALL check: rst_f pulled low asynchronously in WR_RS (between edges) -> rf_we, busy and out_sel go 0 immediately, no WR_RT write follows, and the state is IDLE after release.
REQ-034 The bench SHALL check: rs=0 (0xFFFFFFFF), rt=15 (0x00000001) -> full-width values are swapped intact at the address extremes.

Source files
------------

// File: rtl/swap_ctrl.sv
// swap_ctrl
// Exchanges the contents of two register-file entries. It reads both
// operands in one cycle, then writes them back crossed over in two cycles.
// The operands are held locally, so the second write still uses the
// pre-swap value even though the first write has already overwritten rs.
//
// Ports
//   clk                 single clock, rising edge
//   rst_f               asynchronous reset, active low
//   start               swap request, only looked at while idle
//   rs_addr, rt_addr    register pair to swap
//   rs_data, rt_data    combinational read data for rs_raddr / rt_raddr
//   rs_raddr, rt_raddr  latched read addresses
//   swap_a, swap_b      held operands (old rs / old rt) for the write-data mux
//   out_sel             write-data mux select: 0 -> swap_a, 1 -> swap_b
//   wb_addr             register-file write address
//   rf_we               register-file write enable
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; latches the address pair when start is seen
// READ   | read data valid; operands captured on the exit edge
// WR_RS  | writes old rt into rs
// WR_RT  | writes old rs into rt
// DONE   | done pulse, then back to IDLE
module swap_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              start,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [ADDR_W-1:0] rs_raddr,
    output logic [ADDR_W-1:0] rt_raddr,
    output logic [DATA_W-1:0] swap_a,
    output logic [DATA_W-1:0] swap_b,
    output logic              out_sel,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              rf_we,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WR_RS = 3'd2,
        S_WR_RT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_rs;
    logic [ADDR_W-1:0] r_rt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;

    // State register
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_READ;
            // Swapping a register with itself needs no writes.
            S_READ:  w_next = (r_rs == r_rt) ? S_DONE : S_WR_RS;
            S_WR_RS: w_next = S_WR_RT;
            S_WR_RT: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rf_we   = 1'b0;
        out_sel = 1'b0;
        wb_addr = '0;
        busy    = (r_state != S_IDLE);
        done    = 1'b0;
        case (r_state)
            S_WR_RS: begin
                rf_we   = 1'b1;
                out_sel = 1'b1;
                wb_addr = r_rs;
            end
            S_WR_RT: begin
                rf_we   = 1'b1;
                out_sel = 1'b0;
                wb_addr = r_rt;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Address latch and operand capture. The operands are captured on the
    // edge leaving READ and held until the next swap reaches READ again.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_rs <= '0;
            r_rt <= '0;
            r_a  <= '0;
            r_b  <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_rs <= rs_addr;
                r_rt <= rt_addr;
            end
            if (r_state == S_READ) begin
                r_a <= rs_data;
                r_b <= rt_data;
            end
        end
    end

    assign rs_raddr = r_rs;
    assign rt_raddr = r_rt;
    assign swap_a   = r_a;
    assign swap_b   = r_b;

endmodule
